// File: rtl/pkt_len_framer_pkg.sv
// Shared types and helpers for the packet-length framer.
// Target computation maps the command length encoding onto the last beat index.
package pkt_len_framer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PASS = 1'b1
    } state_t;

    // Result is truncated by the caller to its own LEN_W (LEN_W <= 32).
    function automatic logic [31:0] calc_target(input logic [31:0] len, input logic minus_one);
        return minus_one ? len : len - 32'd1;
    endfunction

endpackage

// File: rtl/pkt_len_framer_beat_counter.sv
// Beat counter with loadable target; at_target flags the final beat index.
// Priority: clear, then load, then increment.
module pkt_len_framer_beat_counter #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [LEN_W-1:0] i_target,
    input  logic             i_incr,
    input  logic             i_clear,
    output logic [LEN_W-1:0] o_count,
    output logic             o_at_target
);

    logic [LEN_W-1:0] r_count;
    logic [LEN_W-1:0] r_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_target <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_target <= i_target;
            r_count  <= '0;
        end else if (i_incr) begin
            r_count <= r_count + LEN_W'(1);
        end
    end

    assign o_count     = r_count;
    assign o_at_target = (r_count == r_target);

endmodule

// File: rtl/pkt_len_framer.sv
// Length-framed stream gate: accepts a length command, then forwards exactly that
// many beats with out_last on the final one; supports zero-length and abort.
module pkt_len_framer
    import pkt_len_framer_pkg::*;
#(
    parameter int LEN_W         = 8,
    parameter int DATA_W        = 32,
    parameter bit LEN_MINUS_ONE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_val,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              cmd_rdy,
    input  logic              in_val,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_rdy,
    output logic              out_val,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_rdy,
    input  logic              abort,
    output logic              busy,
    output logic [LEN_W-1:0]  beat_count,
    output logic              pkt_done
);

    // Handshake: a command or beat moves only in a cycle where its valid and
    // ready are both high at the rising edge; neither side may depend on the
    // other having already moved.
    state_t           r_state;
    logic             r_pkt_done;
    logic             r_done_pend;

    logic             w_pass;
    logic             w_xfer;
    logic             w_last;
    logic             w_cmd_rdy;
    logic             w_cmd_acc;
    logic             w_zero_len;
    logic             w_load;
    logic             w_incr;
    logic             w_clear;
    logic             w_at_target;
    logic             w_done_xfer;
    logic             w_zero_acc;
    logic [1:0]       w_done_sum;
    logic [LEN_W-1:0] w_target;
    logic [LEN_W-1:0] w_count;

    assign w_pass     = (r_state == PASS);
    assign w_xfer     = in_val & out_rdy & w_pass & ~rst;
    assign w_last     = w_pass & w_at_target;
    assign w_zero_len = !LEN_MINUS_ONE && (cmd_len == '0);
    assign w_target   = LEN_W'(calc_target(32'(cmd_len), LEN_MINUS_ONE));

    // Ready on the last beat lets the next packet start with no bubble; abort blocks it.
    assign w_cmd_rdy  = ~rst & (~w_pass | (w_xfer & w_last & ~abort));
    assign w_cmd_acc  = cmd_val & w_cmd_rdy;

    assign w_load     = w_cmd_acc & ~w_zero_len;
    assign w_incr     = w_xfer & ~w_last;
    assign w_clear    = (w_pass & abort) | (w_xfer & w_last & ~w_load);

    // A last beat plus a zero-length command in one cycle yields two pulses,
    // so the second one is parked in r_done_pend for the following cycle.
    assign w_done_xfer = w_xfer & w_last & ~abort;
    assign w_zero_acc  = w_cmd_acc & w_zero_len;
    assign w_done_sum  = 2'(w_done_xfer) + 2'(w_zero_acc) + 2'(r_done_pend);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pkt_done  <= 1'b0;
            r_done_pend <= 1'b0;
        end else begin
            r_pkt_done  <= |w_done_sum;
            r_done_pend <= w_done_sum[1];
            if (w_pass && abort) begin
                r_state <= IDLE;
            end else if (w_cmd_acc) begin
                r_state <= w_zero_len ? IDLE : PASS;
            end else if (w_xfer && w_last) begin
                r_state <= IDLE;
            end
        end
    end

    pkt_len_framer_beat_counter #(
        .LEN_W(LEN_W)
    ) u_beat_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_target   (w_target),
        .i_incr     (w_incr),
        .i_clear    (w_clear),
        .o_count    (w_count),
        .o_at_target(w_at_target)
    );

    assign cmd_rdy    = w_cmd_rdy;
    assign in_rdy     = out_rdy & w_pass & ~rst;
    assign out_val    = in_val & w_pass & ~rst;
    assign out_data   = in_data;
    assign out_last   = w_last;
    assign busy       = w_pass;
    assign beat_count = w_count;
    assign pkt_done   = r_pkt_done;

endmodule

// File: tb/tb_pkt_len_framer.sv
// Bench for pkt_len_framer: default instance (count encoding) plus a 4-bit
// minus-one instance; beats are scoreboarded as {last, data}.
module tb_pkt_len_framer;

    localparam int DATA_W = 32;
    localparam int W      = DATA_W + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic              cmd_val0, cmd_rdy0, in_val0, in_rdy0, out_val0, out_last0, out_rdy0;
    logic              abort0, busy0, pkt_done0;
    logic [7:0]        cmd_len0, beat_count0;
    logic [DATA_W-1:0] in_data0, out_data0;

    logic              cmd_val1, cmd_rdy1, in_val1, in_rdy1, out_val1, out_last1, out_rdy1;
    logic              abort1, busy1, pkt_done1;
    logic [3:0]        cmd_len1, beat_count1;
    logic [DATA_W-1:0] in_data1, out_data1;

    pkt_len_framer dut0 (
        .clk(clk), .rst(rst),
        .cmd_val(cmd_val0), .cmd_len(cmd_len0), .cmd_rdy(cmd_rdy0),
        .in_val(in_val0), .in_data(in_data0), .in_rdy(in_rdy0),
        .out_val(out_val0), .out_data(out_data0), .out_last(out_last0), .out_rdy(out_rdy0),
        .abort(abort0), .busy(busy0), .beat_count(beat_count0), .pkt_done(pkt_done0)
    );

    pkt_len_framer #(.LEN_W(4), .DATA_W(DATA_W), .LEN_MINUS_ONE(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .cmd_val(cmd_val1), .cmd_len(cmd_len1), .cmd_rdy(cmd_rdy1),
        .in_val(in_val1), .in_data(in_data1), .in_rdy(in_rdy1),
        .out_val(out_val1), .out_data(out_data1), .out_last(out_last1), .out_rdy(out_rdy1),
        .abort(abort1), .busy(busy1), .beat_count(beat_count1), .pkt_done(pkt_done1)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [W-1:0] exp0_q[$];
    logic [W-1:0] exp1_q[$];
    logic [DATA_W-1:0] src0, src1, next_exp0, next_exp1;
    logic        xfer0 = 1'b0;
    logic        xfer1 = 1'b0;
    int          pd0 = 0;
    int          pd1 = 0;
    int          idx1 = 0;
    bit          rand_mode = 1'b0;
    int          pd_base;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard side: compare every accepted output beat against the queue head.
    always @(negedge clk) begin
        logic [W-1:0] e;
        xfer0 = 1'b0;
        xfer1 = 1'b0;
        if (!rst && out_val0 && out_rdy0) begin
            xfer0 = 1'b1;
            if (exp0_q.size() == 0) check("extra_beat0", 64'(out_val0), 64'd0);
            else begin
                e = exp0_q.pop_front();
                check("beat0", 64'({out_last0, out_data0}), 64'(e));
            end
        end
        if (!rst && out_val1 && out_rdy1) begin
            xfer1 = 1'b1;
            if (exp1_q.size() == 0) check("extra_beat1", 64'(out_val1), 64'd0);
            else begin
                e = exp1_q.pop_front();
                check("beat1", 64'({out_last1, out_data1}), 64'(e));
                check("bc1", 64'(beat_count1), 64'(idx1));
                idx1 = e[W-1] ? 0 : idx1 + 1;
            end
        end
        if (pkt_done0) pd0++;
        if (pkt_done1) pd1++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (xfer0) begin src0 = src0 + 1; in_data0 = src0; end
        if (xfer1) begin src1 = src1 + 1; in_data1 = src1; end
        if (rand_mode) begin
            in_val0  = 1'($urandom_range(0, 1));
            out_rdy0 = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_cmd0(input int len);
        bit done = 1'b0;
        cmd_len0 = 8'(len);
        cmd_val0 = 1'b1;
        for (int k = 0; k < len; k++) begin
            exp0_q.push_back({k == len - 1, next_exp0});
            next_exp0 = next_exp0 + 1;
        end
        for (int c = 0; c < 200 && !done; c++) begin
            #1;
            done = cmd_rdy0;
            tick();
        end
        check("cmd_acc0", 64'(done), 64'd1);
    endtask

    task automatic send_cmd1(input int len);
        bit done = 1'b0;
        cmd_len1 = 4'(len);
        cmd_val1 = 1'b1;
        for (int k = 0; k <= len; k++) begin
            exp1_q.push_back({k == len, next_exp1});
            next_exp1 = next_exp1 + 1;
        end
        for (int c = 0; c < 200 && !done; c++) begin
            #1;
            done = cmd_rdy1;
            tick();
        end
        check("cmd_acc1", 64'(done), 64'd1);
    endtask

    task automatic drain0();
        for (int c = 0; c < 1000 && exp0_q.size() != 0; c++) tick();
        check("drain0", 64'(exp0_q.size()), 64'd0);
    endtask

    task automatic drain1();
        for (int c = 0; c < 1000 && exp1_q.size() != 0; c++) tick();
        check("drain1", 64'(exp1_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pat [6];
        int   cnt;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        // Reset block
        rst = 1'b1;
        cmd_val0 = 0; cmd_len0 = 0; in_val0 = 1; out_rdy0 = 1; abort0 = 0;
        cmd_val1 = 0; cmd_len1 = 0; in_val1 = 1; out_rdy1 = 1; abort1 = 0;
        src0 = $urandom; src1 = $urandom;
        in_data0 = src0; in_data1 = src1;
        next_exp0 = src0; next_exp1 = src1;
        tick(); tick();
        #1;
        check("rst_cmd_rdy", 64'(cmd_rdy0), 64'd0);
        check("rst_in_rdy", 64'(in_rdy0), 64'd0);
        check("rst_out_val", 64'(out_val0), 64'd0);
        rst = 1'b0;
        tick();
        #1;
        check("idle_busy", 64'(busy0), 64'd0);
        check("idle_count", 64'(beat_count0), 64'd0);
        check("idle_pkt_done", 64'(pkt_done0), 64'd0);
        check("idle_cmd_rdy", 64'(cmd_rdy0), 64'd1);

        // Single 3-beat packet
        pd_base = pd0;
        send_cmd0(3);
        cmd_val0 = 1'b0;
        tick(); #1;
        check("t1_last_early", 64'(out_last0), 64'd0);
        check("t1_count1", 64'(beat_count0), 64'd1);
        tick(); #1;
        check("t1_last_3rd", 64'(out_last0), 64'd1);
        check("t1_cmd_rdy_last", 64'(cmd_rdy0), 64'd1);
        check("t1_count2", 64'(beat_count0), 64'd2);
        tick(); #1;
        check("t1_pkt_done", 64'(pkt_done0), 64'd1);
        check("t1_busy_after", 64'(busy0), 64'd0);
        tick(); #1;
        check("t1_pkt_done_off", 64'(pkt_done0), 64'd0);
        check("t1_pd_count", 64'(pd0 - pd_base), 64'd1);
        drain0();

        // Back-to-back 2 then 1 with no bubble
        pd_base = pd0;
        send_cmd0(2);
        send_cmd0(1);
        cmd_val0 = 1'b0;
        #1;
        check("t2_beat3_val", 64'(out_val0), 64'd1);
        check("t2_beat3_last", 64'(out_last0), 64'd1);
        check("t2_pd_first", 64'(pkt_done0), 64'd1);
        tick(); #1;
        check("t2_pd_second", 64'(pkt_done0), 64'd1);
        check("t2_busy", 64'(busy0), 64'd0);
        tick(); #1;
        check("t2_pd_off", 64'(pkt_done0), 64'd0);
        check("t2_pd_count", 64'(pd0 - pd_base), 64'd2);
        drain0();

        // Zero-length packet
        pd_base = pd0;
        send_cmd0(0);
        cmd_val0 = 1'b0;
        #1;
        check("t3_busy", 64'(busy0), 64'd0);
        check("t3_out_val", 64'(out_val0), 64'd0);
        check("t3_pkt_done", 64'(pkt_done0), 64'd1);
        tick(); #1;
        check("t3_pd_off", 64'(pkt_done0), 64'd0);
        check("t3_pd_count", 64'(pd0 - pd_base), 64'd1);

        // Minus-one encoding, 4-bit length: 15 -> 16 beats
        send_cmd1(15);
        cmd_val1 = 1'b0;
        drain1();
        tick(); tick(); #1;
        check("t4_pd_count", 64'(pd1), 64'd1);
        check("t4_busy", 64'(busy1), 64'd0);

        // Backpressure pattern on a 4-beat packet
        send_cmd0(4);
        cmd_val0 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            out_rdy0 = pat[i];
            #1;
            check("t5_in_rdy", 64'(in_rdy0), 64'(pat[i]));
            check("t5_count", 64'(beat_count0), 64'(cnt));
            tick();
            if (pat[i]) cnt++;
        end
        out_rdy0 = 1'b1;
        #1;
        check("t5_busy_done", 64'(busy0), 64'd0);
        drain0();

        // Abort after 2 of 5 beats, third beat still forwarded
        tick();
        pd_base = pd0;
        send_cmd0(5);
        cmd_val0 = 1'b0;
        tick(); tick();
        abort0 = 1'b1;
        cmd_val0 = 1'b1;
        cmd_len0 = 8'd1;
        #1;
        check("t6_abort_cmd_rdy", 64'(cmd_rdy0), 64'd0);
        check("t6_abort_fwd", 64'(out_val0), 64'd1);
        tick();
        abort0 = 1'b0;
        cmd_val0 = 1'b0;
        exp0_q.delete();
        next_exp0 = src0;
        #1;
        check("t6_busy", 64'(busy0), 64'd0);
        check("t6_count", 64'(beat_count0), 64'd0);
        tick(); #1;
        check("t6_no_pd", 64'(pd0 - pd_base), 64'd0);
        send_cmd0(1);
        cmd_val0 = 1'b0;
        drain0();
        tick(); tick();
        check("t6_pd_after", 64'(pd0 - pd_base), 64'd1);

        // Reset mid-packet
        send_cmd0(5);
        cmd_val0 = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp0_q.delete();
        next_exp0 = src0;
        #1;
        check("t7_busy", 64'(busy0), 64'd0);
        check("t7_count", 64'(beat_count0), 64'd0);
        tick();

        // Random lengths and random valid/ready
        pd_base = pd0;
        rand_mode = 1'b1;
        for (int p = 0; p < 10; p++) send_cmd0(int'($urandom_range(0, 5)));
        cmd_val0 = 1'b0;
        drain0();
        rand_mode = 1'b0;
        in_val0 = 1'b1;
        out_rdy0 = 1'b1;
        tick(); tick(); tick();
        check("t8_pd_count", 64'(pd0 - pd_base), 64'd10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pkt_len_framer.md
Name: pkt_len_framer

Overview:
- Parametrised successor to the team's single-length beat counter FSM.
- Accepts a packet-length command on a valid/ready command channel, then passes exactly that many data beats from an input stream to an output stream.
- Asserts out_last on the final beat and returns to idle without a bubble when the next command is already waiting.
- Adds configurable length encoding, zero-length handling, abort, and status outputs. Sits between a header parser and downstream stream consumers.

Parameters:
- LEN_W, 8, width of cmd_len and of the beat counter.
- DATA_W, 32, width of the data path.
- LEN_MINUS_ONE, 0, 0: cmd_len = beat count (0 = zero-length packet); 1: cmd_len = beats-1 (max 2^LEN_W beats, no zero-length).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_val  in  1  command valid
- cmd_len  in  LEN_W  packet length per LEN_MINUS_ONE encoding
- cmd_rdy  out  1  command ready
- in_val  in  1  input beat valid
- in_data  in  DATA_W  input beat data
- in_rdy  out  1  input beat ready
- out_val  out  1  output beat valid
- out_data  out  DATA_W  output beat data
- out_last  out  1  final beat of packet
- out_rdy  in  1  output ready
- abort  in  1  drop remainder of current packet
- busy  out  1  state is PASS
- beat_count  out  LEN_W  beats already transferred in the current packet
- pkt_done  out  1  registered one-cycle pulse per completed or zero-length packet

Behaviour:
- States: IDLE, PASS. 1-bit enum, no X member. Reset: IDLE, counter 0, target 0, pkt_done 0. While rst is high, cmd_rdy, in_rdy and out_val are all 0.
- Data path is combinational pass-through with zero latency:
  - out_data = in_data.
  - out_val = in_val & (state==PASS).
  - in_rdy = out_rdy & (state==PASS).
  - A beat transfers when in_val & out_rdy & state==PASS.
- Target register, loaded on command accept:
  - LEN_MINUS_ONE=1: target = cmd_len.
  - LEN_MINUS_ONE=0: target = cmd_len-1.
- out_last = (state==PASS) & (count==target). It is valid only while out_val.
- cmd_rdy = IDLE, or (PASS & beat transfer & out_last). The second term gives zero-bubble back-to-back packets.
- IDLE, on cmd_val & cmd_rdy:
  - Non-zero length: load target, count=0, go to PASS.
  - LEN_MINUS_ONE=0 and cmd_len==0: stay IDLE, pulse pkt_done next cycle, pass no beats.
- PASS, on each transfer:
  - Not last: count += 1.
  - Last: count=0, pkt_done=1 next cycle.
  - Last with a command accepted in the same cycle: reload target and stay in PASS (go to IDLE instead if the new command is zero-length, which also pulses pkt_done once more next cycle). Two back-to-back pkt_done pulses are legal.
  - Last with no command: go to IDLE.
- Counter never wraps: the maximum value is target, which is ≤ 2^LEN_W-1.
- abort, sampled each cycle:
  - In PASS: go to IDLE, count=0, no pkt_done. A beat transfer in the same cycle is still forwarded, but the command channel is not accepted that cycle.
  - In IDLE: ignored. cmd_rdy stays high.
- beat_count = count register. busy = state==PASS.
- Reset mid-packet: return to IDLE at once and discard the partial packet.
- No transfer occurs when out_rdy=0. Counter and state hold.

Decomposition:
- pkt_len_framer_pkg: state enum typedef (IDLE=0, PASS=1) and a localparam function for target computation.
- One sub-module, beat_counter (LEN_W): load/incr/clear inputs, count and at_target outputs.

Test Plan:
- LEN_MINUS_ONE=0, cmd_len=3, in_val and out_rdy held high -> exactly 3 beats; out_last on the 3rd; pkt_done pulse in the cycle after; cmd_rdy high on the 3rd beat.
- Back-to-back cmd_len=2 then 1, cmd_val held -> 3 consecutive beats with no bubble; out_last on beats 2 and 3; two pkt_done pulses.
- LEN_MINUS_ONE=0, cmd_len=0 -> no out_val, state stays IDLE, pkt_done pulses once.
- LEN_MINUS_ONE=1, LEN_W=4, cmd_len=15 -> 16 beats; beat_count reaches 15 on the last beat; out_last only then.
- out_rdy toggled 1,0,0,1 during cmd_len=4 -> in_rdy mirrors out_rdy; count advances only on transfers; still 4 beats total.
- abort after 2 of 5 beats -> state IDLE next cycle, no pkt_done, next cmd_len=1 yields a single beat with out_last.
